// File: rtl/bf_route_pkg.sv
// Shared constants and helpers for the butterfly output router.
package bf_route_pkg;

  localparam logic MODE_R2 = 1'b0;
  localparam logic MODE_R4 = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Flat source number: butterfly b, upper (1) or lower (0) result.
  function automatic int unsigned src_index(input int unsigned b, input logic upper);
    return (b << 1) + 32'(upper);
  endfunction

endpackage

// File: rtl/bf_ctrl_delay.sv
// Control-word delay line with a short (LAT_R2) and long (LAT_R4) tap.
module bf_ctrl_delay #(
  parameter int unsigned PAY_W  = 8,
  parameter int unsigned LAT_R2 = 8,
  parameter int unsigned LAT_R4 = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             long_i,
  input  logic             in_valid_i,
  input  logic [PAY_W-1:0] in_pay_i,
  output logic             tap_valid_o,
  output logic [PAY_W-1:0] tap_pay_o
);

  logic [LAT_R4-1:0] valid_q;
  logic [PAY_W-1:0]  pay_q [LAT_R4];

  // In short mode a word is killed once past the short tap so it cannot
  // resurface at the long tap after a later mode switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid_i;
      for (int unsigned i = 1; i < LAT_R4; i++) begin
        valid_q[i] <= (i == LAT_R2 && !long_i) ? 1'b0 : valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pay_q[0] <= in_pay_i;
    for (int unsigned i = 1; i < LAT_R4; i++) begin
      pay_q[i] <= pay_q[i-1];
    end
  end

  assign tap_valid_o = long_i ? valid_q[LAT_R4-1] : valid_q[LAT_R2-1];
  assign tap_pay_o   = long_i ? pay_q[LAT_R4-1]   : pay_q[LAT_R2-1];

endmodule

// File: rtl/bf_out_router.sv
// Routes butterfly result pairs onto bank write lanes, with delayed control,
// registered outputs, drain-before-mode-switch and a sticky drop flag.
module bf_out_router
  import bf_route_pkg::*;
#(
  parameter  int unsigned DATA_W = 12,
  parameter  int unsigned NUM_BF = 2,
  parameter  int unsigned ADDR_W = 6,
  parameter  int unsigned LAT_R2 = 8,
  parameter  int unsigned LAT_R4 = 16,
  localparam int unsigned NLANE  = 2 * NUM_BF,
  localparam int unsigned SEL_W  = (clog2(NLANE) < 1) ? 1 : clog2(NLANE),
  localparam int unsigned CNT_W  = clog2(LAT_R4 + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode_req,
  output logic                    mode,
  output logic                    ctrl_ready,
  input  logic                    ctrl_valid,
  input  logic [NLANE*SEL_W-1:0]  ctrl_sel,
  input  logic [NLANE-1:0]        ctrl_lane_en,
  input  logic [ADDR_W-1:0]       ctrl_addr,
  input  logic [NUM_BF*DATA_W-1:0] bf_upper,
  input  logic [NUM_BF*DATA_W-1:0] bf_lower,
  output logic [NLANE*DATA_W-1:0] d_out,
  output logic [NLANE-1:0]        d_we,
  output logic [ADDR_W-1:0]       d_addr,
  output logic                    d_valid,
  output logic [CNT_W-1:0]        inflight,
  output logic                    drop_err
);

  localparam int unsigned PAY_W = NLANE*SEL_W + NLANE + ADDR_W;
  localparam int unsigned NSRC  = 1 << SEL_W;

  logic                    mode_q, mode_d;
  logic [CNT_W-1:0]        inflight_q, inflight_d;
  logic                    drop_q, drop_d;
  logic [NLANE*DATA_W-1:0] d_out_q, d_out_d;
  logic [NLANE-1:0]        d_we_q, d_we_d;
  logic [ADDR_W-1:0]       d_addr_q, d_addr_d;
  logic                    d_valid_q, d_valid_d;

  logic                    accept;
  logic                    tap_valid;
  logic [PAY_W-1:0]        tap_pay;
  logic [NLANE*SEL_W-1:0]  tap_sel;
  logic [NLANE-1:0]        tap_en;
  logic [ADDR_W-1:0]       tap_addr;
  logic [DATA_W-1:0]       src_c [NSRC];
  logic [NLANE*DATA_W-1:0] lane_c;

  assign ctrl_ready = (mode_req == mode_q);
  assign accept     = ctrl_valid && ctrl_ready;

  bf_ctrl_delay #(
    .PAY_W (PAY_W),
    .LAT_R2(LAT_R2),
    .LAT_R4(LAT_R4)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .long_i     (mode_q == MODE_R4),
    .in_valid_i (accept),
    .in_pay_i   ({ctrl_sel, ctrl_lane_en, ctrl_addr}),
    .tap_valid_o(tap_valid),
    .tap_pay_o  (tap_pay)
  );

  assign {tap_sel, tap_en, tap_addr} = tap_pay;

  // Source table; unused encodings (s >= NLANE) read as zero.
  always_comb begin
    for (int unsigned i = 0; i < NSRC; i++) src_c[SEL_W'(i)] = '0;
    for (int unsigned b = 0; b < NUM_BF; b++) begin
      src_c[SEL_W'(src_index(b, 1'b1))] = bf_upper[b*DATA_W +: DATA_W];
      src_c[SEL_W'(src_index(b, 1'b0))] = bf_lower[b*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    lane_c = '0;
    for (int unsigned l = 0; l < NLANE; l++) begin
      lane_c[l*DATA_W +: DATA_W] = src_c[tap_sel[l*SEL_W +: SEL_W]];
    end
  end

  always_comb begin
    mode_d     = mode_q;
    inflight_d = inflight_q;
    drop_d     = drop_q | (ctrl_valid && !ctrl_ready);
    d_out_d    = d_out_q;
    d_addr_d   = d_addr_q;
    d_we_d     = '0;
    d_valid_d  = 1'b0;
    if (tap_valid) begin
      d_out_d   = lane_c;
      d_we_d    = tap_en;
      d_addr_d  = tap_addr;
      d_valid_d = 1'b1;
    end
    if (accept && !tap_valid) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!accept && tap_valid) begin
      inflight_d = inflight_q - 1'b1;
    end
    // Empty pipeline implies no word at the tap, so the tap switch is safe.
    if (mode_req != mode_q && inflight_q == '0) begin
      mode_d = mode_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_R2;
      inflight_q <= '0;
      drop_q     <= 1'b0;
      d_out_q    <= '0;
      d_we_q     <= '0;
      d_addr_q   <= '0;
      d_valid_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      d_out_q    <= d_out_d;
      d_we_q     <= d_we_d;
      d_addr_q   <= d_addr_d;
      d_valid_q  <= d_valid_d;
    end
  end

  assign mode     = mode_q;
  assign inflight = inflight_q;
  assign drop_err = drop_q;
  assign d_out    = d_out_q;
  assign d_we     = d_we_q;
  assign d_addr   = d_addr_q;
  assign d_valid  = d_valid_q;

endmodule

// File: tb/tb_bf_out_router.sv
// Randomised bench for bf_out_router against a timestamp-queue reference model.
module tb_bf_out_router;

  localparam int DW = 12, NL = 4, SW = 2, L2 = 8, L4 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mode_req, mode, ctrl_ready, ctrl_valid;
  logic [7:0]  ctrl_sel;
  logic [3:0]  ctrl_lane_en;
  logic [5:0]  ctrl_addr;
  logic [23:0] bf_upper, bf_lower;
  logic [47:0] d_out;
  logic [3:0]  d_we;
  logic [5:0]  d_addr;
  logic        d_valid, drop_err;
  logic [4:0]  inflight;

  // Wide configuration instance: NUM_BF=4, DATA_W=16, short latencies
  logic         mode_req4, mode4, ready4, cv4, dval4, drop4;
  logic [23:0]  sel4;
  logic [7:0]   en4, we4;
  logic [5:0]   addr4, daddr4;
  logic [63:0]  up4, lo4;
  logic [127:0] dout4;
  logic [1:0]   infl4;

  bf_out_router u_dut (
    .clk(clk), .rst(rst), .mode_req(mode_req), .mode(mode), .ctrl_ready(ctrl_ready),
    .ctrl_valid(ctrl_valid), .ctrl_sel(ctrl_sel), .ctrl_lane_en(ctrl_lane_en),
    .ctrl_addr(ctrl_addr), .bf_upper(bf_upper), .bf_lower(bf_lower), .d_out(d_out),
    .d_we(d_we), .d_addr(d_addr), .d_valid(d_valid), .inflight(inflight), .drop_err(drop_err)
  );

  bf_out_router #(.DATA_W(16), .NUM_BF(4), .ADDR_W(6), .LAT_R2(2), .LAT_R4(3)) u_dut4 (
    .clk(clk), .rst(rst), .mode_req(mode_req4), .mode(mode4), .ctrl_ready(ready4),
    .ctrl_valid(cv4), .ctrl_sel(sel4), .ctrl_lane_en(en4), .ctrl_addr(addr4),
    .bf_upper(up4), .bf_lower(lo4), .d_out(dout4), .d_we(we4), .d_addr(daddr4),
    .d_valid(dval4), .inflight(infl4), .drop_err(drop4)
  );

  typedef struct {
    int         emit;
    logic [7:0] sel;
    logic [3:0] en;
    logic [5:0] addr;
  } word_t;

  word_t       q[$];
  int          cyc, tick, n_vec, n_err;
  logic        mode_m, drop_m, dv_m;
  logic [47:0] dout_m;
  logic [3:0]  we_m;
  logic [5:0]  addr_m;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference: each accepted word is stamped with the edge at which it must appear.
  task automatic model_edge();
    int    pend;
    word_t w;
    cyc++;
    if (rst) begin
      q.delete();
      mode_m = 1'b0; drop_m = 1'b0; dv_m = 1'b0;
      dout_m = '0; we_m = '0; addr_m = '0;
      return;
    end
    pend = q.size();
    dv_m = 1'b0;
    we_m = '0;
    if (q.size() > 0 && q[0].emit == cyc) begin
      w = q.pop_front();
      dv_m   = 1'b1;
      we_m   = w.en;
      addr_m = w.addr;
      for (int l = 0; l < NL; l++) begin
        int s;
        s = int'(w.sel[l*SW +: SW]);
        dout_m[l*DW +: DW] = (s % 2 != 0) ? bf_upper[(s/2)*DW +: DW] : bf_lower[(s/2)*DW +: DW];
      end
    end
    if (ctrl_valid) begin
      if (mode_req == mode_m) begin
        w.emit = cyc + (mode_m ? L4 : L2);
        w.sel  = ctrl_sel;
        w.en   = ctrl_lane_en;
        w.addr = ctrl_addr;
        q.push_back(w);
      end else begin
        drop_m = 1'b1;
      end
    end
    if (mode_req != mode_m && pend == 0) mode_m = mode_req;
  endtask

  task automatic compare_all();
    chk("d_valid",    128'(d_valid),    128'(dv_m));
    chk("d_we",       128'(d_we),       128'(we_m));
    chk("d_addr",     128'(d_addr),     128'(addr_m));
    chk("d_out",      128'(d_out),      128'(dout_m));
    chk("inflight",   128'(inflight),   128'(q.size()));
    chk("mode",       128'(mode),       128'(mode_m));
    chk("ctrl_ready", 128'(ctrl_ready), 128'(mode_req == mode_m));
    chk("drop_err",   128'(drop_err),   128'(drop_m));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic rnd_bf();
    bf_upper = 24'($urandom);
    bf_lower = 24'($urandom);
  endtask

  task automatic idle(input int n);
    ctrl_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      rnd_bf();
      step();
    end
  endtask

  task automatic put(input logic [7:0] sel, input logic [3:0] en, input logic [5:0] addr);
    ctrl_valid   = 1'b1;
    ctrl_sel     = sel;
    ctrl_lane_en = en;
    ctrl_addr    = addr;
    rnd_bf();
    step();
    ctrl_valid   = 1'b0;
  endtask

  task automatic wait_mode();
    for (int i = 0; i < 100 && mode_req != mode_m; i++) idle(1);
    chk("mode_settle", 128'(mode), 128'(mode_req));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int peak, nval;
    n_vec = 0; n_err = 0; cyc = 0; tick = 0;
    mode_m = 1'b0; drop_m = 1'b0; dv_m = 1'b0; dout_m = '0; we_m = '0; addr_m = '0;
    rst = 1'b1; mode_req = 1'b0; ctrl_valid = 1'b0; ctrl_sel = '0; ctrl_lane_en = '0;
    ctrl_addr = '0; bf_upper = '0; bf_lower = '0;
    mode_req4 = 1'b0; cv4 = 1'b0; sel4 = '0; en4 = '0; addr4 = '0; up4 = '0; lo4 = '0;
    step();
    step();
    rst = 1'b0;

    // Single radix-2 word, identity routing, data present only at the exit edge
    put(8'hE4, 4'hF, 6'd5);
    for (int i = 1; i <= L2; i++) begin
      if (i == L2) begin
        bf_lower = {12'h033, 12'h011};
        bf_upper = {12'h044, 12'h022};
      end else begin
        rnd_bf();
      end
      step();
    end
    chk("t1_dout",  128'(d_out),   128'(48'h044033022011));
    chk("t1_valid", 128'(d_valid), 128'(1));
    chk("t1_addr",  128'(d_addr),  128'(5));
    idle(4);

    // Radix-4 back-to-back burst with incrementing sources
    mode_req = 1'b1;
    wait_mode();
    peak = 0;
    nval = 0;
    for (int i = 0; i < 44; i++) begin
      ctrl_valid   = (i < 20);
      ctrl_sel     = 8'($urandom);
      ctrl_lane_en = 4'hF;
      ctrl_addr    = 6'(i);
      bf_lower     = {12'(tick*4 + 2), 12'(tick*4)};
      bf_upper     = {12'(tick*4 + 3), 12'(tick*4 + 1)};
      tick++;
      step();
      if (int'(inflight) > peak) peak = int'(inflight);
      if (d_valid) nval++;
    end
    ctrl_valid = 1'b0;
    chk("r4_peak",  128'(peak), 128'(L4));
    chk("r4_count", 128'(nval), 128'(20));

    // Mode switch with traffic and drops while draining
    mode_req = 1'b0;
    wait_mode();
    for (int i = 0; i < 3; i++) put(8'($urandom), 4'($urandom), 6'($urandom));
    mode_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ctrl_valid = (i < 3);
      ctrl_sel = 8'($urandom); ctrl_lane_en = 4'hF; ctrl_addr = 6'($urandom);
      rnd_bf();
      step();
    end
    ctrl_valid = 1'b0;
    wait_mode();
    chk("drop_sticky", 128'(drop_err), 128'(1));

    // Toggle back before drain completes: ready returns at once, no switch
    put(8'($urandom), 4'hF, 6'd40);
    mode_req = 1'b0;
    idle(3);
    mode_req = 1'b1;
    #1;
    chk("toggle_ready", 128'(ctrl_ready), 128'(1));
    idle(L4);

    // Broadcast of bf1 lower with masked lanes (radix-4 latency)
    put(8'hAA, 4'b0101, 6'd9);
    idle(L4);
    chk("bc_we",   128'(d_we),  128'(4'b0101));
    chk("bc_dout", 128'(d_out), 128'({4{bf_lower[23:12]}}));
    idle(3);

    // Random traffic with occasional mode requests
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) mode_req = ~mode_req;
      ctrl_valid   = ($urandom_range(0, 3) != 0);
      ctrl_sel     = 8'($urandom);
      ctrl_lane_en = 4'($urandom);
      ctrl_addr    = 6'($urandom);
      rnd_bf();
      step();
    end
    ctrl_valid = 1'b0;

    // Reset in the middle of radix-4 traffic
    mode_req = 1'b1;
    wait_mode();
    for (int i = 0; i < 5; i++) put(8'($urandom), 4'hF, 6'(i));
    idle(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    nval = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (d_valid) nval++;
    end
    chk("rst_no_valid", 128'(nval), 128'(0));

    // Wide instance: lane i sources 7-i, lane 0 swept over every source
    for (int s = 0; s < 8; s++) begin
      up4 = {$urandom, $urandom};
      lo4 = {$urandom, $urandom};
      sel4 = '0;
      for (int i = 1; i < 8; i++) sel4[i*3 +: 3] = 3'(7 - i);
      sel4[2:0] = 3'(s);
      en4 = 8'hFF;
      addr4 = 6'(s);
      cv4 = 1'b1;
      step();
      cv4 = 1'b0;
      step();
      chk("w4_early", 128'(dval4), 128'(0));
      step();
      chk("w4_valid", 128'(dval4),  128'(1));
      chk("w4_addr",  128'(daddr4), 128'(s));
      chk("w4_we",    128'(we4),    128'(8'hFF));
      for (int i = 0; i < 8; i++) begin
        int v;
        v = (i == 0) ? s : 7 - i;
        chk("w4_lane", 128'(dout4[i*16 +: 16]),
            128'((v % 2 != 0) ? up4[(v/2)*16 +: 16] : lo4[(v/2)*16 +: 16]));
      end
    end
    step();
    chk("w4_infl",  128'(infl4),  128'(0));
    chk("w4_drop",  128'(drop4),  128'(0));
    chk("w4_mode",  128'(mode4),  128'(0));
    chk("w4_ready", 128'(ready4), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
